// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants, types and the BCD-to-segment pattern table for the
// four-digit scanned 7-segment display driver.
package seg7_scan_driver_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_t;

  // Active-low {g,f,e,d,c,b,a} pattern; anything outside 0..9 shows a dash.
  function automatic logic [6:0] digit_pattern(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit/control inputs and display outputs of the scan driver.
// master = counter side + display pins as seen by the producer, slave = driver.
interface seg7_scan_driver_if;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] digit4;
  logic       adj;
  logic       sel;
  logic       lz_blank;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output digit1, digit2, digit3, digit4, adj, sel, lz_blank,
    input  seg, dp, an
  );

  modport slave (
    input  digit1, digit2, digit3, digit4, adj, sel, lz_blank,
    output seg, dp, an
  );
endinterface

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; dash for codes above 9.
module bcd_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Table lookup, no state.
  always_comb begin
    o_seg = digit_pattern(i_bcd);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver: snapshots the BCD digits once per scan,
// multiplexes them with a per-slot anode guard interval, optional leading-zero
// suppression and blinking of the selected digit pair in adjust mode.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int GUARD     = 1000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic               clk_used,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int CW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_C   = CW'(GUARD);
  localparam logic [BW-1:0] BLNK_LAST = BW'(BLINK_DIV - 1);

  logic [CW-1:0] r_cnt;
  slot_t         r_slot;
  logic          r_first;
  logic [3:0]    r_snap [4];
  logic          r_sel_l;
  logic [BW-1:0] r_bcnt;
  blink_t        r_blink;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_wrap;
  logic          w_scan_end;
  logic          w_guard;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg;
  logic          w_lz;
  logic          w_blink_blank;

  assign w_wrap     = (r_cnt == CNT_LAST);
  assign w_scan_end = w_wrap && (r_slot == 2'd3);
  assign w_guard    = (r_cnt < GUARD_C);
  assign w_digit    = r_snap[r_slot];

  bcd_to_seg7 u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg)
  );

  // Slot timer and slot index; index steps on each timer wrap.
  always_ff @(posedge clk_used or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_slot <= '0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_slot <= r_slot + 2'd1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // Digit snapshot at scan start (and right after reset) so a scan never mixes
  // old and new digits; pair select is resampled only at slot boundaries.
  always_ff @(posedge clk_used or negedge rst_n) begin
    if (!rst_n) begin
      r_first <= 1'b1;
      r_sel_l <= 1'b0;
      for (int i = 0; i < 4; i++) r_snap[i] <= '0;
    end else begin
      r_first <= 1'b0;
      if (r_first || w_scan_end) begin
        r_snap[0] <= bus.digit1;
        r_snap[1] <= bus.digit2;
        r_snap[2] <= bus.digit3;
        r_snap[3] <= bus.digit4;
      end
      if (r_first || w_wrap) r_sel_l <= bus.sel;
    end
  end

  // Blink half-period timer; held cleared with phase ON outside adjust mode.
  always_ff @(posedge clk_used or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt  <= '0;
      r_blink <= BLINK_ON;
    end else if (!bus.adj) begin
      r_bcnt  <= '0;
      r_blink <= BLINK_ON;
    end else if (r_bcnt == BLNK_LAST) begin
      r_bcnt  <= '0;
      r_blink <= (r_blink == BLINK_ON) ? BLINK_OFF : BLINK_ON;
    end else begin
      r_bcnt  <= r_bcnt + 1'b1;
    end
  end

  // Leading-zero suppression; digit4 is never suppressed, invalid codes never are.
  always_comb begin
    w_lz = 1'b0;
    if (bus.lz_blank) begin
      case (r_slot)
        2'd0:    w_lz = (r_snap[0] == 4'd0);
        2'd1:    w_lz = (r_snap[0] == 4'd0) && (r_snap[1] == 4'd0);
        2'd2:    w_lz = (r_snap[0] == 4'd0) && (r_snap[1] == 4'd0) &&
                        (r_snap[2] == 4'd0);
        default: w_lz = 1'b0;
      endcase
    end
  end

  // Live adj gates the blank so dropping adjust mode reveals the pair at once.
  assign w_blink_blank = bus.adj && (r_blink == BLINK_OFF) && (r_sel_l == r_slot[1]);

  // Registered display outputs; guard interval keeps all anodes off.
  always_ff @(posedge clk_used or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else if (w_guard) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b1000 >> r_slot);
      r_seg <= (w_lz || w_blink_blank) ? SEG_BLANK : w_seg;
      r_dp  <= !((r_slot == 2'd1) && !w_blink_blank);
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with short scan/guard/blink periods.
module tb_seg7_scan_driver;

  localparam int S = 8;
  localparam int G = 2;
  localparam int B = 64;

  logic clk_used = 1'b0;
  logic rst_n    = 1'b0;

  seg7_scan_driver_if bus();

  seg7_scan_driver #(.SCAN_DIV(S), .GUARD(G), .BLINK_DIV(B)) dut (
    .clk_used (clk_used),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk_used = ~clk_used;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: edges since reset release, snapshot, latched sel, adj run length.
  int m_t;
  int m_snap [4];
  int m_sel;
  int m_adjrun;

  logic [6:0] ref_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [6:0] ref_pat(input int d);
    if (d > 9) return 7'h3F;
    return ref_tab[d];
  endfunction

  task automatic set_inputs(input int d1, input int d2, input int d3, input int d4,
                            input logic a, input logic s, input logic lz);
    bus.digit1 = 4'(d1); bus.digit2 = 4'(d2);
    bus.digit3 = 4'(d3); bus.digit4 = 4'(d4);
    bus.adj = a; bus.sel = s; bus.lz_blank = lz;
  endtask

  task automatic model_reset();
    m_t = 0; m_sel = 0; m_adjrun = 0;
    for (int i = 0; i < 4; i++) m_snap[i] = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk_used);
    @(negedge clk_used);
    model_reset();
    rst_n = 1'b1;
  endtask

  // One clock: predict the output produced by this edge, advance, sample at +1.
  task automatic tick(output logic [3:0] ea, output logic [6:0] es, output logic ed);
    int cnt, slot;
    bit lz, blink;
    cnt  = m_t % S;
    slot = (m_t / S) % 4;
    if (cnt < G) begin
      ea = 4'hF; es = 7'h7F; ed = 1'b1;
    end else begin
      ea = 4'hF;
      ea[3 - slot] = 1'b0;
      lz = bus.lz_blank &&
           ((slot == 0 && m_snap[0] == 0) ||
            (slot == 1 && m_snap[0] == 0 && m_snap[1] == 0) ||
            (slot == 2 && m_snap[0] == 0 && m_snap[1] == 0 && m_snap[2] == 0));
      blink = bus.adj && (((m_adjrun / B) % 2) == 1) && (m_sel == ((slot >= 2) ? 1 : 0));
      es = (lz || blink) ? 7'h7F : ref_pat(m_snap[slot]);
      ed = (slot == 1 && !blink) ? 1'b0 : 1'b1;
    end
    @(posedge clk_used);
    if (m_t == 0 || (m_t % (4 * S)) == 4 * S - 1) begin
      m_snap[0] = bus.digit1; m_snap[1] = bus.digit2;
      m_snap[2] = bus.digit3; m_snap[3] = bus.digit4;
    end
    if (m_t == 0 || cnt == S - 1) m_sel = bus.sel;
    m_adjrun = bus.adj ? m_adjrun + 1 : 0;
    m_t++;
    #1;
  endtask

  function automatic int slot_of(input logic [3:0] an);
    case (an)
      4'b0111: return 0;
      4'b1011: return 1;
      4'b1101: return 2;
      4'b1110: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic test_reset();
    logic [3:0] ea; logic [6:0] es; logic ed;
    int n;
    set_inputs(1, 2, 3, 4, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 13; i++) begin
      tick(ea, es, ed);
      n_checks++;
      if ({bus.an, bus.seg, bus.dp} !== {ea, es, ed}) begin
        n_fail++;
        $display("FAIL reset_pre t=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 i, bus.an, bus.seg, bus.dp, ea, es, ed);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.an, bus.seg, bus.dp} !== {4'hF, 7'h7F, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_async got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1",
               bus.an, bus.seg, bus.dp);
    end
    @(negedge clk_used);
    model_reset();
    rst_n = 1'b1;
    n = 0;
    do begin
      tick(ea, es, ed);
      n++;
      n_checks++;
      if ({bus.an, bus.seg, bus.dp} !== {ea, es, ed}) begin
        n_fail++;
        $display("FAIL reset_post n=%0d got an=%b seg=%h want an=%b seg=%h",
                 n, bus.an, bus.seg, ea, es);
      end
    end while (bus.an === 4'hF && n < 20);
    n_checks++;
    if (n !== G + 1 || bus.an !== 4'b0111) begin
      n_fail++;
      $display("FAIL reset_latency got %0d cycles an=%b want %0d cycles an=0111",
               n, bus.an, G + 1);
    end
  endtask

  task automatic test_scan();
    logic [3:0] ea; logic [6:0] es; logic ed;
    logic [6:0] want [4];
    int off_cnt, sl;
    want[0] = 7'h79; want[1] = 7'h24; want[2] = 7'h30; want[3] = 7'h19;
    set_inputs(1, 2, 3, 4, 0, 0, 0);
    do_reset();
    off_cnt = 0;
    for (int i = 0; i < 4 * S; i++) begin
      tick(ea, es, ed);
      n_checks++;
      if ({bus.an, bus.seg, bus.dp} !== {ea, es, ed}) begin
        n_fail++;
        $display("FAIL scan_model t=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 i, bus.an, bus.seg, bus.dp, ea, es, ed);
      end
      sl = slot_of(bus.an);
      if (bus.an === 4'hF) off_cnt++;
      n_checks++;
      if (bus.an !== 4'hF && (sl < 0 || bus.seg !== want[sl] || bus.dp !== (sl != 1))) begin
        n_fail++;
        $display("FAIL scan_digit t=%0d got an=%b seg=%h dp=%b", i, bus.an, bus.seg, bus.dp);
      end
    end
    n_checks++;
    if (off_cnt !== 4 * G) begin
      n_fail++;
      $display("FAIL scan_guard got %0d off cycles want %0d", off_cnt, 4 * G);
    end
  endtask

  task automatic test_snapshot();
    logic [3:0] ea; logic [6:0] es; logic ed;
    set_inputs(1, 2, 3, 9, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 8 * S; i++) begin
      if (i == S + 4) bus.digit4 = 4'd5;
      tick(ea, es, ed);
      n_checks++;
      if ({bus.an, bus.seg, bus.dp} !== {ea, es, ed}) begin
        n_fail++;
        $display("FAIL snap_model t=%0d got an=%b seg=%h want an=%b seg=%h",
                 i, bus.an, bus.seg, ea, es);
      end
      if (bus.an === 4'b1110) begin
        n_checks++;
        if (bus.seg !== ((i < 4 * S) ? 7'h10 : 7'h12)) begin
          n_fail++;
          $display("FAIL snap_digit4 t=%0d got seg=%h want %h",
                   i, bus.seg, (i < 4 * S) ? 7'h10 : 7'h12);
        end
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [3:0] ea; logic [6:0] es; logic ed;
    int dig [3][4];
    logic [6:0] want [3][4];
    int sl;
    dig[0] = '{0, 0, 0, 7};  want[0] = '{7'h7F, 7'h7F, 7'h7F, 7'h78};
    dig[1] = '{0, 0, 5, 0};  want[1] = '{7'h7F, 7'h7F, 7'h12, 7'h40};
    dig[2] = '{0, 0, 12, 0}; want[2] = '{7'h7F, 7'h7F, 7'h3F, 7'h40};
    for (int c = 0; c < 3; c++) begin
      set_inputs(dig[c][0], dig[c][1], dig[c][2], dig[c][3], 0, 0, 1);
      do_reset();
      for (int i = 0; i < 4 * S; i++) begin
        tick(ea, es, ed);
        n_checks++;
        if ({bus.an, bus.seg, bus.dp} !== {ea, es, ed}) begin
          n_fail++;
          $display("FAIL lz_model case=%0d t=%0d got an=%b seg=%h want an=%b seg=%h",
                   c, i, bus.an, bus.seg, ea, es);
        end
        sl = slot_of(bus.an);
        if (sl >= 0) begin
          n_checks++;
          if (bus.seg !== want[c][sl] || bus.dp !== (sl != 1)) begin
            n_fail++;
            $display("FAIL lz_digit case=%0d slot=%0d got seg=%h dp=%b want seg=%h",
                     c, sl, bus.seg, bus.dp, want[c][sl]);
          end
        end
      end
    end
  endtask

  task automatic test_blink();
    logic [3:0] ea; logic [6:0] es; logic ed;
    logic [6:0] want [4];
    logic [6:0] w;
    logic wd;
    int sl;
    want[0] = 7'h79; want[1] = 7'h24; want[2] = 7'h30; want[3] = 7'h19;
    set_inputs(1, 2, 3, 4, 1, 1, 0);
    do_reset();
    for (int i = 0; i < 2 * B + 4 * S; i++) begin
      if (i == 2 * B) bus.adj = 1'b0;
      tick(ea, es, ed);
      n_checks++;
      if ({bus.an, bus.seg, bus.dp} !== {ea, es, ed}) begin
        n_fail++;
        $display("FAIL blink_model t=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 i, bus.an, bus.seg, bus.dp, ea, es, ed);
      end
      sl = slot_of(bus.an);
      if (sl >= 0) begin
        if (i >= B && i < 2 * B && sl >= 2) begin
          w = 7'h7F; wd = 1'b1;
        end else begin
          w = want[sl]; wd = (sl != 1);
        end
        n_checks++;
        if (bus.seg !== w || bus.dp !== wd) begin
          n_fail++;
          $display("FAIL blink_digit t=%0d slot=%0d got seg=%h dp=%b want seg=%h dp=%b",
                   i, sl, bus.seg, bus.dp, w, wd);
        end
      end
    end
  endtask

  task automatic test_free_run();
    logic [3:0] ea; logic [6:0] es; logic ed;
    set_inputs(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      bus.digit1 = 4'($urandom_range(0, 15));
      bus.digit2 = 4'($urandom_range(0, 15));
      bus.digit3 = 4'($urandom_range(0, 15));
      bus.digit4 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) bus.adj = ~bus.adj;
      if ($urandom_range(0, 19) == 0)  bus.sel = ~bus.sel;
      if ($urandom_range(0, 99) == 0)  bus.lz_blank = ~bus.lz_blank;
      if (i == 100) bus.adj = 1'b1;
      tick(ea, es, ed);
      n_checks++;
      if ({bus.an, bus.seg, bus.dp} !== {ea, es, ed}) begin
        n_fail++;
        $display("FAIL free_model t=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 i, bus.an, bus.seg, bus.dp, ea, es, ed);
      end
      n_checks++;
      if (!(bus.an inside {4'hF, 4'b0111, 4'b1011, 4'b1101, 4'b1110}) ||
          !(bus.seg inside {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                            7'h78, 7'h00, 7'h10, 7'h3F, 7'h7F})) begin
        n_fail++;
        $display("FAIL free_legal t=%0d got an=%b seg=%h", i, bus.an, bus.seg);
      end
    end
  endtask

  initial begin
    set_inputs(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_scan();
    test_snapshot();
    test_lz_blank();
    test_blink();
    test_free_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
